// File: rtl/arc4_prga.sv
// ============================================================================
// Module      : arc4_prga
// Description : ARC4 keystream generator and decryptor. Walks a permuted S
//               array, swaps entries in place and writes the plaintext.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arc4_prga (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_LEN_A = 4'd1;
    localparam logic [3:0] c_LEN_D = 4'd2;
    localparam logic [3:0] c_SI_A  = 4'd3;
    localparam logic [3:0] c_SI_D  = 4'd4;
    localparam logic [3:0] c_SJ_A  = 4'd5;
    localparam logic [3:0] c_SJ_D  = 4'd6;
    localparam logic [3:0] c_WR_I  = 4'd7;
    localparam logic [3:0] c_WR_J  = 4'd8;
    localparam logic [3:0] c_PAD_A = 4'd9;
    localparam logic [3:0] c_PAD_D = 4'd10;
    localparam logic [3:0] c_WR_PT = 4'd11;
    localparam logic [3:0] c_DONE  = 4'd12;

    logic [3:0] r_state;
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_k;
    logic [7:0] r_len;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic [7:0] r_pad;
    logic [7:0] r_ct_byte;
    logic [7:0] r_s_addr;
    logic [7:0] r_s_wrdata;
    logic       r_s_wren;
    logic [7:0] r_ct_addr;
    logic [7:0] r_pt_addr;
    logic       r_pt_wren;
    logic [7:0] w_pt_wrdata;

    // The length byte is echoed to pt[0] in the very cycle it arrives from the
    // ciphertext memory, so it passes straight through instead of being
    // registered a cycle later.
    assign w_pt_wrdata = (r_state == c_LEN_D) ? ct_rddata : (r_pad ^ r_ct_byte);

    assign rdy       = (r_state == c_IDLE);
    assign s_addr    = r_s_addr;
    assign s_wrdata  = r_s_wrdata;
    assign s_wren    = r_s_wren;
    assign ct_addr   = r_ct_addr;
    assign pt_addr   = r_pt_addr;
    assign pt_wrdata = w_pt_wrdata;
    assign pt_wren   = r_pt_wren;

    // Memory outputs are loaded on the edge that enters the state using them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_i        <= 8'd0;
            r_j        <= 8'd0;
            r_k        <= 8'd0;
            r_len      <= 8'd0;
            r_si       <= 8'd0;
            r_sj       <= 8'd0;
            r_pad      <= 8'd0;
            r_ct_byte  <= 8'd0;
            r_s_addr   <= 8'd0;
            r_s_wrdata <= 8'd0;
            r_s_wren   <= 1'b0;
            r_ct_addr  <= 8'd0;
            r_pt_addr  <= 8'd0;
            r_pt_wren  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (en) begin
                        r_i       <= 8'd0;
                        r_j       <= 8'd0;
                        r_k       <= 8'd0;
                        r_ct_addr <= 8'd0;
                        r_state   <= c_LEN_A;
                    end
                end
                c_LEN_A: begin
                    r_pt_addr <= 8'd0;
                    r_pt_wren <= 1'b1;
                    r_state   <= c_LEN_D;
                end
                c_LEN_D: begin
                    r_len     <= ct_rddata;
                    r_pt_wren <= 1'b0;
                    r_i       <= 8'd1;
                    r_k       <= 8'd1;
                    if (ct_rddata == 8'd0) begin
                        r_state <= c_DONE;
                    end else begin
                        r_s_addr <= 8'd1;
                        r_state  <= c_SI_A;
                    end
                end
                c_SI_A: r_state <= c_SI_D;
                c_SI_D: begin
                    r_si     <= s_rddata;
                    r_j      <= r_j + s_rddata;
                    r_s_addr <= r_j + s_rddata;
                    r_state  <= c_SJ_A;
                end
                c_SJ_A: r_state <= c_SJ_D;
                c_SJ_D: begin
                    r_sj       <= s_rddata;
                    r_s_addr   <= r_i;
                    r_s_wrdata <= s_rddata;
                    r_s_wren   <= 1'b1;
                    r_state    <= c_WR_I;
                end
                c_WR_I: begin
                    r_s_addr   <= r_j;
                    r_s_wrdata <= r_si;
                    r_s_wren   <= 1'b1;
                    r_ct_addr  <= r_k;
                    r_state    <= c_WR_J;
                end
                c_WR_J: begin
                    r_s_wren <= 1'b0;
                    r_s_addr <= r_si + r_sj;
                    r_state  <= c_PAD_A;
                end
                c_PAD_A: r_state <= c_PAD_D;
                c_PAD_D: begin
                    r_pad     <= s_rddata;
                    r_ct_byte <= ct_rddata;
                    r_pt_addr <= r_k;
                    r_pt_wren <= 1'b1;
                    r_state   <= c_WR_PT;
                end
                c_WR_PT: begin
                    r_pt_wren <= 1'b0;
                    if (r_k == r_len) begin
                        r_state <= c_DONE;
                    end else begin
                        r_k      <= r_k + 8'd1;
                        r_i      <= r_i + 8'd1;
                        r_s_addr <= r_i + 8'd1;
                        r_state  <= c_SI_A;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_arc4_prga.sv
// ============================================================================
// Module      : tb_arc4_prga
// Description : Self-checking bench for arc4_prga against an ARC4 model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arc4_prga;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] pt_addr, pt_wrdata;
    logic       pt_wren;

    arc4_prga dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rdy      (rdy),
        .s_addr   (s_addr),
        .s_rddata (s_rddata),
        .s_wrdata (s_wrdata),
        .s_wren   (s_wren),
        .ct_addr  (ct_addr),
        .ct_rddata(ct_rddata),
        .pt_addr  (pt_addr),
        .pt_wrdata(pt_wrdata),
        .pt_wren  (pt_wren)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem  [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ld_s   [256];
    logic [7:0] ld_ct  [256];
    logic [7:0] ld_pt  [256];
    logic [7:0] ref_s  [256];
    logic [7:0] ref_pt [256];
    logic [7:0] key_b  [8];
    int         key_len;
    logic       ld_req = 1'b0;

    int  s_wr_total   = 0;
    int  pt_wr_total  = 0;
    int  pt0_total    = 0;
    time pt_last_time = 0;
    time t0;

    int n_chk = 0;
    int n_err = 0;

    // Synchronous memories: address captured at the edge, data valid after it.
    always @(posedge clk) begin
        if (ld_req) begin
            s_mem  <= ld_s;
            ct_mem <= ld_ct;
            pt_mem <= ld_pt;
        end else begin
            s_rddata  <= s_mem[s_addr];
            ct_rddata <= ct_mem[ct_addr];
            if (s_wren) begin
                s_mem[s_addr] <= s_wrdata;
                s_wr_total    <= s_wr_total + 1;
            end
            if (pt_wren) begin
                pt_mem[pt_addr] <= pt_wrdata;
                pt_wr_total     <= pt_wr_total + 1;
                if (pt_addr == 8'd0) pt0_total <= pt0_total + 1;
                pt_last_time    <= $time;
            end
        end
    end

    typedef struct {
        int len;
        int s_mode;    // 0 identity, 1 key "Key", 2 random key
        int ct_mode;   // 0 zeros, 1 known vector, 2 random
        int exp_edges;
        int hold;
    } vec_t;

    logic [7:0] kv_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] kv_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic prepare(input int len, input int s_mode, input int ct_mode);
        int jj, ii;
        logic [7:0] tmp;
        for (int x = 0; x < 256; x++) ld_s[x] = 8'(x);
        if (s_mode != 0) begin
            if (s_mode == 1) begin
                key_len = 3; key_b[0] = 8'h4B; key_b[1] = 8'h65; key_b[2] = 8'h79;
            end else begin
                key_len = $urandom_range(3, 8);
                for (int x = 0; x < 8; x++) key_b[x] = 8'($urandom);
            end
            jj = 0;
            for (int x = 0; x < 256; x++) begin
                jj = (jj + int'(ld_s[x]) + int'(key_b[x % key_len])) & 255;
                tmp = ld_s[x]; ld_s[x] = ld_s[jj]; ld_s[jj] = tmp;
            end
        end
        for (int x = 0; x < 256; x++) begin
            ld_pt[x] = 8'hEE;
            ld_ct[x] = (ct_mode == 0) ? 8'h00 : 8'($urandom);
        end
        if (ct_mode == 1) for (int x = 0; x < 10; x++) ld_ct[x] = kv_ct[x];
        ld_ct[0] = 8'(len);
        // Plain ARC4 keystream applied to the message body.
        ref_s  = ld_s;
        ref_pt = ld_pt;
        ref_pt[0] = 8'(len);
        ii = 0; jj = 0;
        for (int k = 1; k <= len; k++) begin
            ii = (ii + 1) & 255;
            jj = (jj + int'(ref_s[ii])) & 255;
            tmp = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = tmp;
            ref_pt[k] = ld_ct[k] ^ ref_s[(int'(ref_s[ii]) + int'(ref_s[jj])) & 255];
        end
        @(negedge clk); ld_req = 1'b1;
        @(negedge clk); ld_req = 1'b0;
    endtask

    task automatic wait_rdy(input int hold, output int edges);
        edges = -1;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk); #1;
            if (n >= hold - 1) en = 1'b0;
            if (rdy) begin edges = n; break; end
        end
        en = 1'b0;
    endtask

    task automatic check_mems(input string nm);
        int bad;
        bad = -1;
        for (int x = 0; x < 256; x++) if (bad < 0 && pt_mem[x] !== ref_pt[x]) bad = x;
        n_chk++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s pt[%0d]: got %02h, expected %02h", nm, bad, pt_mem[bad], ref_pt[bad]);
        end
        bad = -1;
        for (int x = 0; x < 256; x++) if (bad < 0 && s_mem[x] !== ref_s[x]) bad = x;
        n_chk++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s S[%0d]: got %02h, expected %02h", nm, bad, s_mem[bad], ref_s[bad]);
        end
    endtask

    task automatic run_and_check(input string nm, input int len, input int exp_edges, input int hold);
        int edges, s0, p0, z0;
        s0 = s_wr_total; p0 = pt_wr_total; z0 = pt0_total;
        @(negedge clk); en = 1'b1;
        @(posedge clk); t0 = $time; #1;
        if (hold <= 1) en = 1'b0;
        wait_rdy(hold, edges);
        chk({nm, " rdy edge"}, edges, exp_edges);
        check_mems(nm);
        chk({nm, " pt writes"}, pt_wr_total - p0, len + 1);
        chk({nm, " pt[0] writes"}, pt0_total - z0, 1);
        chk({nm, " s writes"}, s_wr_total - s0, 2 * len);
        chk({nm, " last pt edge"}, int'((pt_last_time - t0) / 10), 2 + 9 * len);
    endtask

    vec_t tbl [9];

    initial begin
        int edges, p0, len;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("reset rdy", int'(rdy), 1);
        chk("reset s_wren", int'(s_wren), 0);
        chk("reset pt_wren", int'(pt_wren), 0);
        chk("reset addrs", int'(s_addr) + int'(ct_addr) + int'(pt_addr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        tbl[0] = '{9,   1, 1, 84,   1};
        tbl[1] = '{2,   0, 0, 21,   1};
        tbl[2] = '{0,   2, 2, 3,    1};
        tbl[3] = '{255, 0, 0, 2298, 1};
        tbl[4] = '{5,   2, 2, 48,   3};
        tbl[5] = '{17,  2, 2, 156,  1};
        tbl[6] = '{1,   0, 2, 12,   2};
        tbl[7] = '{255, 2, 2, 2298, 1};
        tbl[8] = '{3,   1, 2, 30,   4};

        for (int t = 0; t < 9; t++) begin
            prepare(tbl[t].len, tbl[t].s_mode, tbl[t].ct_mode);
            run_and_check($sformatf("vec%0d", t), tbl[t].len, tbl[t].exp_edges, tbl[t].hold);
            if (t == 0) begin
                for (int x = 0; x < 10; x++) chk($sformatf("known pt[%0d]", x), int'(pt_mem[x]), int'(kv_pt[x]));
            end
            if (t == 1) begin
                chk("ident pt[1]", int'(pt_mem[1]), 2);
                chk("ident pt[2]", int'(pt_mem[2]), 5);
                chk("ident S[2]", int'(s_mem[2]), 3);
                chk("ident S[3]", int'(s_mem[3]), 2);
            end
        end

        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 60);
            prepare(len, 2, 2);
            run_and_check($sformatf("rand%0d", r), len, 3 + 9 * len, 1);
        end

        // Reset during WR_I of byte 3, then a clean rerun.
        prepare(9, 1, 1);
        @(negedge clk); en = 1'b1;
        @(posedge clk); t0 = $time; #1; en = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        chk("wr_i s_wren", int'(s_wren), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst s_wren", int'(s_wren), 0);
        chk("midrst pt_wren", int'(pt_wren), 0);
        chk("midrst rdy", int'(rdy), 1);
        @(negedge clk); rst = 1'b0;
        prepare(9, 1, 1);
        run_and_check("after reset", 9, 84, 1);
        for (int x = 0; x < 10; x++) chk($sformatf("rerun pt[%0d]", x), int'(pt_mem[x]), int'(kv_pt[x]));

        // en pulses while busy (edge 5) and right after completion (edge 40).
        prepare(4, 2, 2);
        p0 = pt_wr_total;
        @(negedge clk); en = 1'b1;
        @(posedge clk); t0 = $time; #1; en = 1'b0;
        edges = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 4) en = 1'b1;
            if (n == 5) en = 1'b0;
            if (rdy) begin edges = n; break; end
        end
        en = 1'b0;
        chk("busy rdy edge", edges, 39);
        chk("busy pt writes", pt_wr_total - p0, 5);
        check_mems("busy");
        en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        chk("restart accepted", int'(rdy), 0);
        wait_rdy(1, edges);
        chk("restart rdy edge", edges, 39);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
